// File: rtl/ddr3_iod_ctrl_pkg.sv
// Shared types for the DDR3 RESET_N IOD controller: sequencer/delay state encodings and tap type.
package ddr3_iod_ctrl_pkg;

   localparam int unsigned TapW = 8;
   typedef logic [TapW-1:0] tap_t;

   typedef enum logic [2:0] {
      SeqIdle,
      SeqSync,
      SeqHoldLow,
      SeqWaitCke,
      SeqDone
   } seq_state_e;

   typedef enum logic [1:0] {
      DlyOff,
      DlyInit,
      DlyIdle,
      DlyStep
   } dly_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ddr3_dly_stepper.sv
// Delay-line stepper for the RESET_N IOD: reloads the line once, then walks it one tap at a
// time toward a requested absolute tap, aborting on the IOD out-of-range flag.
module ddr3_dly_stepper
   import ddr3_iod_ctrl_pkg::*;
#(
   parameter int unsigned TAP_W   = 8,
   parameter int unsigned MAX_TAP = 255
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             req_valid_i,
   input  logic [TAP_W-1:0] req_tap_i,
   input  logic             oor_i,
   output logic             req_ready_o,
   output logic [TAP_W-1:0] cur_tap_o,
   output logic             err_o,
   output logic             load_o,
   output logic             move_o,
   output logic             dir_o,
   output logic             busy_o
);

   localparam logic [TAP_W-1:0] MaxTap = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] LoadTap = TAP_W'(1);

   dly_state_e       st_q, st_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [TAP_W-1:0] tgt_q, tgt_d;
   logic [TAP_W-1:0] req_clamp;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic             load_q, load_d;
   logic             move_q, move_d;
   logic             dir_q, dir_d;

   assign req_clamp = (req_tap_i > MaxTap) ? MaxTap : req_tap_i;

   always_comb begin
      st_d   = st_q;
      tap_d  = tap_q;
      tgt_d  = tgt_q;
      dir_d  = dir_q;
      load_d = 1'b0;
      move_d = 1'b0;
      err_d  = err_q | oor_i;
      unique case (st_q)
         DlyOff: begin
            if (en_i) begin
               st_d   = DlyInit;
               load_d = 1'b1;
            end
         end
         DlyInit: begin
            st_d  = DlyIdle;
            tap_d = LoadTap;
         end
         DlyIdle: begin
            if (req_valid_i && ready_q) begin
               st_d  = DlyStep;
               tgt_d = req_clamp;
               // Direction is settled here, one cycle ahead of the first MOVE.
               if (req_clamp != tap_q) dir_d = (req_clamp > tap_q);
            end
         end
         DlyStep: begin
            if (oor_i) begin
               st_d = DlyIdle;
            end else if (move_q) begin
               if (tap_q == tgt_q) st_d = DlyIdle;
            end else if (tap_q == tgt_q) begin
               st_d = DlyIdle;
            end else begin
               move_d = 1'b1;
               tap_d  = dir_q ? tap_q + 1'b1 : tap_q - 1'b1;
            end
         end
         default: st_d = DlyOff;
      endcase
      ready_d = (st_d == DlyIdle);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q    <= DlyOff;
         tap_q   <= LoadTap;
         tgt_q   <= LoadTap;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         load_q  <= 1'b0;
         move_q  <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         tap_q   <= tap_d;
         tgt_q   <= tgt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         load_q  <= load_d;
         move_q  <= move_d;
         dir_q   <= dir_d;
      end
   end

   assign req_ready_o = ready_q;
   assign cur_tap_o   = tap_q;
   assign err_o       = err_q;
   assign load_o      = load_q;
   assign move_o      = move_q;
   assign dir_o       = dir_q;
   assign busy_o      = (st_q == DlyStep);

endmodule

// File: rtl/ddr3_reset_n_iod_ctrl.sv
// DDR3 RESET_N IOD controller: runs the JEDEC power-up timing on the pin and hands the
// output delay line to the tap stepper once the TX gearing is out of sync reset.
module ddr3_reset_n_iod_ctrl
   import ddr3_iod_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_RST_CYC  = 8,
   parameter int unsigned T_RST_LOW_CYC = 40000,
   parameter int unsigned T_CKE_CYC     = 100000,
   parameter int unsigned TAP_W         = 8,
   parameter int unsigned MAX_TAP       = 255
) (
   input  logic             FAB_CLK,
   input  logic             ARST_N,
   input  logic             init_start,
   output logic             init_done,
   input  logic             rst_force,
   input  logic             dly_req_valid,
   input  logic [TAP_W-1:0] dly_req_tap,
   output logic             dly_req_ready,
   output logic [TAP_W-1:0] dly_cur_tap,
   output logic             dly_err,
   output logic [3:0]       TX_DATA_0,
   output logic [3:0]       OE_DATA_0,
   output logic             ODT_EN_0,
   output logic             TX_SYNC_RST,
   output logic             DELAY_LINE_LOAD_0,
   output logic             DELAY_LINE_MOVE_0,
   output logic             DELAY_LINE_DIRECTION_0,
   input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

   localparam int unsigned CntW = $clog2(max3(SYNC_RST_CYC, T_RST_LOW_CYC, T_CKE_CYC)) + 1;

   seq_state_e      seq_q, seq_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tx_q, tx_d;
   logic            sync_rst_q, sync_rst_d;
   logic            done_q, done_d;
   logic            dly_en;
   logic            dly_busy;

   always_comb begin
      seq_d      = seq_q;
      cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      tx_d       = tx_q;
      sync_rst_d = sync_rst_q;
      done_d     = done_q;
      unique case (seq_q)
         SeqIdle: begin
            cnt_d = '0;
            if (init_start) seq_d = SeqSync;
         end
         SeqSync: begin
            if (cnt_q == CntW'(SYNC_RST_CYC - 1)) begin
               seq_d      = SeqHoldLow;
               cnt_d      = '0;
               sync_rst_d = 1'b0;
            end
         end
         SeqHoldLow: begin
            // Releasing the pin waits out any in-flight delay-line step.
            if (cnt_q >= CntW'(T_RST_LOW_CYC - 1) && !dly_busy) begin
               seq_d = SeqWaitCke;
               cnt_d = '0;
               tx_d  = 1'b1;
            end
         end
         SeqWaitCke: begin
            if (cnt_q == CntW'(T_CKE_CYC - 1)) begin
               seq_d  = SeqDone;
               done_d = 1'b1;
            end
         end
         SeqDone: cnt_d = cnt_q;
         default: seq_d = SeqIdle;
      endcase
      // Forced reset has pin priority over everything past the gearing sync.
      if (rst_force && seq_q != SeqIdle && seq_q != SeqSync) begin
         seq_d  = SeqHoldLow;
         cnt_d  = '0;
         tx_d   = 1'b0;
         done_d = 1'b0;
      end
   end

   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         seq_q      <= SeqIdle;
         cnt_q      <= '0;
         tx_q       <= 1'b0;
         sync_rst_q <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         seq_q      <= seq_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         sync_rst_q <= sync_rst_d;
         done_q     <= done_d;
      end
   end

   assign dly_en = (seq_q == SeqHoldLow) || (seq_q == SeqWaitCke) || (seq_q == SeqDone);

   ddr3_dly_stepper #(
      .TAP_W   (TAP_W),
      .MAX_TAP (MAX_TAP)
   ) u_stepper (
      .clk_i       (FAB_CLK),
      .rst_ni      (ARST_N),
      .en_i        (dly_en),
      .req_valid_i (dly_req_valid),
      .req_tap_i   (dly_req_tap),
      .oor_i       (DELAY_LINE_OUT_OF_RANGE_0),
      .req_ready_o (dly_req_ready),
      .cur_tap_o   (dly_cur_tap),
      .err_o       (dly_err),
      .load_o      (DELAY_LINE_LOAD_0),
      .move_o      (DELAY_LINE_MOVE_0),
      .dir_o       (DELAY_LINE_DIRECTION_0),
      .busy_o      (dly_busy)
   );

   assign TX_DATA_0   = {4{tx_q}};
   assign OE_DATA_0   = 4'hF;
   assign ODT_EN_0    = 1'b0;
   assign TX_SYNC_RST = sync_rst_q;
   assign init_done   = done_q;

endmodule
